store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 30 +++
 rtl/store_align.sv | 36 +++
 rtl/store_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_store_buffer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store size encodings, parameter
// defaults, drain FSM state encoding and the alignment legality helper.
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT      = 8;
  localparam int SB_ADDR_LIMIT_DEFAULT = 2048;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } st_size_e;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_REQ  = 1'b1
  } drain_state_e;

  // True when the size code is illegal or the access is not naturally aligned.
  function automatic logic is_misaligned(input st_size_e size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane alignment: turns a store's size, low address bits and unaligned
// data into lane-replicated write data and a byte strobe.
module store_align
  import store_buffer_pkg::*;
(
  input  st_size_e    size,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  // Lane select and data replication per access size.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wdata = '0;
    wstrb = '0;
    case (size)
      SIZE_BYTE: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{data[7:0]}};
      end
      SIZE_HALF: begin
        wstrb = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{data[15:0]}};
      end
      SIZE_WORD: begin
        wstrb = 4'b1111;
        wdata = data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: holds executed stores until the ROB commits them, then drains
// committed stores in order to data memory. Flushes discard uncommitted stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = SB_DEPTH_DEFAULT,
  parameter int ADDR_LIMIT = SB_ADDR_LIMIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exception_sig,
  input  logic                   mret_sig,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_inst_num,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [1:0]             st_size,
  input  logic                   commit_valid,
  input  logic [31:0]            commit_inst_num,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wstrb,
  output logic                   lb_memwrite,
  output logic [31:0]            lb_address,
  output logic [31:0]            lb_inst_num,
  output logic                   addr_exception,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] head, tail;
  logic [IDX_W-1:0] head_idx, tail_idx, next_idx, sel_idx;

  logic [DEPTH-1:0] ent_valid, ent_committed;
  logic [31:0]      ent_inst_num [DEPTH];
  logic [31:0]      ent_addr     [DEPTH];
  logic [31:0]      ent_data     [DEPTH];
  st_size_e         ent_size     [DEPTH];

  drain_state_e state;

  logic             flush, st_fire, st_illegal, push, pop;
  logic             head_rdy, next_rdy;
  logic [DEPTH-1:0] commit_hit, committed_now, drop;
  logic [PTR_W-1:0] flush_tail;
  logic [IDX_W-1:0] scan_idx;
  logic             found;
  logic [31:0]      align_wdata;
  logic [3:0]       align_wstrb;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign next_idx = head_idx + IDX_W'(1);

  assign count    = tail - head;
  assign st_ready = count < PTR_W'(DEPTH);

  // A store arriving during a flush is dropped outright.
  assign flush      = exception_sig | mret_sig;
  assign st_fire    = st_valid & st_ready & ~flush;
  assign st_illegal = (st_addr >= 32'(ADDR_LIMIT)) |
                      is_misaligned(st_size_e'(st_size), st_addr[1:0]);
  assign push       = st_fire & ~st_illegal;
  assign pop        = (state == DRAIN_REQ) & mem_ack;

  // Commit match against every live entry; at most one tag can match.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit[i] = commit_valid & ent_valid[i] & (ent_inst_num[i] == commit_inst_num);
    end
  end

  // A same-cycle commit counts when deciding which entries survive a flush.
  assign committed_now = ent_committed | commit_hit;

  // Find the oldest uncommitted entry; it and everything younger is dropped on flush.
  always_comb begin
    flush_tail = tail;
    drop       = '0;
    found      = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + IDX_W'(i);
      if (PTR_W'(i) < count) begin
        if (!found && !committed_now[scan_idx]) begin
          found      = 1'b1;
          flush_tail = head + PTR_W'(i);
        end
        if (found) drop[scan_idx] = 1'b1;
      end
    end
  end

  assign head_rdy = ent_valid[head_idx] & ent_committed[head_idx];
  assign next_rdy = ent_valid[next_idx] & ent_committed[next_idx];

  // In REQ the entry after head is the one loaded on the acknowledging edge.
  assign sel_idx = (state == DRAIN_REQ) ? next_idx : head_idx;

  store_align u_align (
    .size   (ent_size[sel_idx]),
    .offset (ent_addr[sel_idx][1:0]),
    .data   (ent_data[sel_idx]),
    .wdata  (align_wdata),
    .wstrb  (align_wstrb)
  );

  // Pointer and per-entry status bookkeeping: commit, flush, push, pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      ent_valid     <= '0;
      ent_committed <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic; the later
      // per-bit updates below deliberately override the whole-vector ones.
      ent_committed <= ent_committed | commit_hit;
      if (flush) begin
        tail      <= flush_tail;
        ent_valid <= ent_valid & ~drop;
      end else if (push) begin
        tail                <= tail + PTR_W'(1);
        ent_valid[tail_idx] <= 1'b1;
      end
      if (pop) begin
        head                    <= head + PTR_W'(1);
        ent_valid[head_idx]     <= 1'b0;
        ent_committed[head_idx] <= 1'b0;
      end
    end
  end

  // Entry payload capture on a legal push.
  // NOTE: payload storage has no reset; the valid bits alone say what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_inst_num[tail_idx] <= st_inst_num;
      ent_addr[tail_idx]     <= st_addr;
      ent_data[tail_idx]     <= st_data;
      ent_size[tail_idx]     <= st_size_e'(st_size);
    end
  end

  // One-cycle notices: load-buffer ordering check and address exception.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lb_memwrite    <= 1'b0;
      lb_address     <= '0;
      lb_inst_num    <= '0;
      addr_exception <= 1'b0;
    end else begin
      lb_memwrite    <= push;
      addr_exception <= st_fire & st_illegal;
      if (push) begin
        lb_address  <= st_addr;
        lb_inst_num <= st_inst_num;
      end
    end
  end

  // Drain FSM: issue the committed head to memory and hold it until acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= DRAIN_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        DRAIN_IDLE: begin
          if (head_rdy) begin
            state     <= DRAIN_REQ;
            mem_req   <= 1'b1;
            mem_addr  <= ent_addr[sel_idx];
            mem_wdata <= align_wdata;
            mem_wstrb <= align_wstrb;
          end
        end
        DRAIN_REQ: begin
          if (mem_ack) begin
            if (next_rdy) begin
              mem_addr  <= ent_addr[sel_idx];
              mem_wdata <= align_wdata;
              mem_wstrb <= align_wstrb;
            end else begin
              state   <= DRAIN_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        default: begin
          state   <= DRAIN_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a scoreboard of expected memory writes
// is filled as stores are issued and drained as the DUT writes memory.
module tb_store_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exception_sig = 1'b0, mret_sig = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_inst_num = '0, st_addr = '0, st_data = '0;
  logic [1:0]  st_size = 2'b00;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_inst_num = '0;
  logic        mem_req, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        lb_memwrite;
  logic [31:0] lb_address, lb_inst_num;
  logic        addr_exception;
  logic [3:0]  count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t sb_q[$];
  int  tests_run = 0;
  int  failures  = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_LIMIT(2048)) dut (
    .clk             (clk),
    .reset           (reset),
    .exception_sig   (exception_sig),
    .mret_sig        (mret_sig),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_inst_num     (st_inst_num),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_size         (st_size),
    .commit_valid    (commit_valid),
    .commit_inst_num (commit_inst_num),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .lb_memwrite     (lb_memwrite),
    .lb_address      (lb_address),
    .lb_inst_num     (lb_inst_num),
    .addr_exception  (addr_exception),
    .count           (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference lane model, written lane by lane.
  function automatic wr_t model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz);
    wr_t w;
    w.addr = a;
    case (sz)
      2'b00: begin
        case (a[1:0])
          2'd0:    w.strb = 4'b0001;
          2'd1:    w.strb = 4'b0010;
          2'd2:    w.strb = 4'b0100;
          default: w.strb = 4'b1000;
        endcase
        w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
      end
      2'b01: begin
        w.strb = a[1] ? 4'b1100 : 4'b0011;
        w.data = {d[15:0], d[15:0]};
      end
      default: begin
        w.strb = 4'b1111;
        w.data = d;
      end
    endcase
    return w;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] tag, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input bit expect_write);
    st_valid    = 1'b1;
    st_inst_num = tag;
    st_addr     = a;
    st_data     = d;
    st_size     = sz;
    if (expect_write) sb_q.push_back(model_write(a, d, sz));
    tick();
    st_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] tag);
    commit_valid    = 1'b1;
    commit_inst_num = tag;
    tick();
    commit_valid = 1'b0;
  endtask

  // Memory responder: wait (bounded) for mem_req, score the write, acknowledge it.
  task automatic serve_write(input string name);
    int  waited = 0;
    wr_t exp;
    while (mem_req !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    tests_run++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL %s: mem_req stayed %b, required 1 within 40 cycles", name, mem_req);
    end else begin
      tests_run++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL %s: unexpected write addr=%h data=%h strb=%b, none required",
                 name, mem_addr, mem_wdata, mem_wstrb);
      end else begin
        exp = sb_q.pop_front();
        if (mem_addr !== exp.addr || mem_wdata !== exp.data || mem_wstrb !== exp.strb) begin
          failures++;
          $display("FAIL %s: got addr=%h data=%h strb=%b, required addr=%h data=%h strb=%b",
                   name, mem_addr, mem_wdata, mem_wstrb, exp.addr, exp.data, exp.strb);
        end
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || lb_memwrite !== 1'b0 || addr_exception !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: mem_req=%b lb_memwrite=%b addr_exception=%b, required 0 0 0",
               mem_req, lb_memwrite, addr_exception);
    end
    tests_run++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d, required 0", count);
    end
    tests_run++;
    if (mem_wstrb !== 4'd0 || mem_addr !== 32'd0 || lb_address !== 32'd0) begin
      failures++;
      $display("FAIL reset_regs: wstrb=%b mem_addr=%h lb_address=%h, required zero",
               mem_wstrb, mem_addr, lb_address);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (st_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b, required 1", st_ready);
    end
  endtask

  task automatic test_word_store();
    logic [31:0] held;
    bit          unstable = 0;
    do_store(32'd5, 32'h40, 32'hDEADBEEF, 2'b10, 1);
    tests_run++;
    if (lb_memwrite !== 1'b1 || lb_address !== 32'h40 || lb_inst_num !== 32'd5) begin
      failures++;
      $display("FAIL word_lb_notice: lb=%b addr=%h tag=%0d, required 1 00000040 5",
               lb_memwrite, lb_address, lb_inst_num);
    end
    tests_run++;
    if (count !== 4'd1) begin
      failures++;
      $display("FAIL word_count: got %0d, required 1", count);
    end
    tick();
    tests_run++;
    if (lb_memwrite !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL word_quiet: lb_memwrite=%b mem_req=%b, required 0 0", lb_memwrite, mem_req);
    end
    do_commit(32'd5);
    tests_run++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL word_req_early: mem_req=%b on commit edge, required 0", mem_req);
    end
    tick();
    tests_run++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL word_req_latency: mem_req=%b one cycle after commit, required 1", mem_req);
    end
    held = mem_wdata;
    repeat (3) begin
      tick();
      if (mem_req !== 1'b1 || mem_wdata !== held || mem_wstrb !== 4'b1111) unstable = 1;
    end
    tests_run++;
    if (unstable) begin
      failures++;
      $display("FAIL word_hold: req=%b data=%h strb=%b, required 1 %h 1111 while unacked",
               mem_req, mem_wdata, mem_wstrb, held);
    end
    serve_write("word_write");
    tests_run++;
    if (count !== 4'd0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL word_pop: count=%0d mem_req=%b, required 0 0", count, mem_req);
    end
  endtask

  task automatic test_lanes();
    do_store(32'd7, 32'h103, 32'h000000AB, 2'b00, 1);
    do_store(32'd8, 32'h102, 32'hFFFF1234, 2'b01, 1);
    do_store(32'd9, 32'h101, 32'h000000CD, 2'b00, 1);
    do_commit(32'd7);
    do_commit(32'd8);
    do_commit(32'd9);
    serve_write("byte_lane3");
    serve_write("half_upper");
    serve_write("byte_lane1");
  endtask

  task automatic test_full();
    wr_t exp;
    for (int i = 0; i < DEPTH; i++)
      do_store(32'(10 + i), 32'(4 * i), 32'(32'h1000 + i), 2'b10, 1);
    tests_run++;
    if (count !== 4'd8 || st_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state: count=%0d st_ready=%b, required 8 0", count, st_ready);
    end
    do_commit(32'd10);
    for (int w = 0; w < 10 && mem_req !== 1'b1; w++) tick();
    exp = sb_q.pop_front();
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== exp.addr || mem_wdata !== exp.data) begin
      failures++;
      $display("FAIL full_drain: req=%b addr=%h data=%h, required 1 %h %h",
               mem_req, mem_addr, mem_wdata, exp.addr, exp.data);
    end
    st_valid    = 1'b1;
    st_inst_num = 32'd99;
    st_addr     = 32'h80;
    st_data     = 32'h99;
    st_size     = 2'b10;
    mem_ack     = 1'b1;
    tick();
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    tests_run++;
    if (count !== 4'd7 || st_ready !== 1'b1 || lb_memwrite !== 1'b0) begin
      failures++;
      $display("FAIL full_no_push: count=%0d st_ready=%b lb=%b, required 7 1 0",
               count, st_ready, lb_memwrite);
    end
    exception_sig = 1'b1;
    tick();
    exception_sig = 1'b0;
    sb_q.delete();  // all seven remaining stores were uncommitted
    tests_run++;
    if (count !== 4'd0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL full_flush: count=%0d mem_req=%b, required 0 0", count, mem_req);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [4] = '{32'd2048, 32'h42, 32'h41, 32'h10};
    logic [1:0]  sizes [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      do_store(32'(40 + i), addrs[i], 32'h55, sizes[i], 0);
      tests_run++;
      if (addr_exception !== 1'b1 || lb_memwrite !== 1'b0 || count !== 4'd0) begin
        failures++;
        $display("FAIL illegal_%0d: exc=%b lb=%b count=%0d, required 1 0 0",
                 i, addr_exception, lb_memwrite, count);
      end
      tick();
      tests_run++;
      if (addr_exception !== 1'b0) begin
        failures++;
        $display("FAIL illegal_pulse_%0d: exc=%b, required 0", i, addr_exception);
      end
    end
  endtask

  task automatic test_flush();
    bit stray = 0;
    for (int t = 1; t <= 4; t++)
      do_store(32'(t), 32'(32'h200 + 4 * t), 32'(32'hA0 + t), 2'b10, 1);
    do_commit(32'd1);
    do_commit(32'd2);
    exception_sig = 1'b1;
    tick();
    exception_sig = 1'b0;
    void'(sb_q.pop_back());  // tag 4 discarded
    void'(sb_q.pop_back());  // tag 3 discarded
    tests_run++;
    if (count !== 4'd2 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL flush_state: count=%0d mem_req=%b, required 2 1", count, mem_req);
    end
    serve_write("flush_tag1");
    serve_write("flush_tag2");
    repeat (10) begin
      tick();
      if (mem_req !== 1'b0) stray = 1;
    end
    tests_run++;
    if (stray || count !== 4'd0) begin
      failures++;
      $display("FAIL flush_discard: stray_req=%0d count=%0d, required 0 0", stray, count);
    end
  endtask

  task automatic test_flush_collision();
    do_store(32'd20, 32'h300, 32'h20, 2'b10, 1);
    do_store(32'd21, 32'h304, 32'h21, 2'b10, 1);
    do_commit(32'd20);
    commit_valid    = 1'b1;
    commit_inst_num = 32'd21;
    mret_sig        = 1'b1;
    st_valid        = 1'b1;
    st_inst_num     = 32'd22;
    st_addr         = 32'h308;
    st_data         = 32'h22;
    st_size         = 2'b10;
    tick();
    commit_valid = 1'b0;
    mret_sig     = 1'b0;
    tests_run++;
    if (count !== 4'd2 || lb_memwrite !== 1'b0) begin
      failures++;
      $display("FAIL collide_commit: count=%0d lb=%b, required 2 0", count, lb_memwrite);
    end
    exception_sig = 1'b1;
    st_addr       = 32'd4000;
    tick();
    exception_sig = 1'b0;
    st_valid      = 1'b0;
    tests_run++;
    if (addr_exception !== 1'b0 || count !== 4'd2) begin
      failures++;
      $display("FAIL collide_illegal: exc=%b count=%0d, required 0 2", addr_exception, count);
    end
    serve_write("collide_tag20");
    serve_write("collide_tag21");
  endtask

  task automatic test_reset_mid_req();
    do_store(32'd30, 32'h10, 32'h30, 2'b10, 1);
    do_store(32'd31, 32'h14, 32'h31, 2'b10, 1);
    do_store(32'd32, 32'h18, 32'h32, 2'b10, 1);
    do_commit(32'd30);
    for (int w = 0; w < 10 && mem_req !== 1'b1; w++) tick();
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL midreq_reset: mem_req=%b count=%0d, required 0 0", mem_req, count);
    end
    sb_q.delete();  // pending writes are lost
    #2;
    reset = 1'b0;
    tick();
    tests_run++;
    if (st_ready !== 1'b1 || count !== 4'd0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL midreq_release: st_ready=%b count=%0d mem_req=%b, required 1 0 0",
               st_ready, count, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_lanes();
    test_full();
    test_illegal();
    test_flush();
    test_flush_collision();
    test_reset_mid_req();
    tests_run++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d writes outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
